// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine.
//   state_t    : controller states
//   idx_width  : bit width of a row-major element index for an N x N matrix
//   cnt_width  : bit width of an i/j/k loop counter
//   min_accw   : smallest C element width that cannot overflow a plain product
package matmul_pkg;

  localparam int unsigned N_DEF    = 2;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned ACCW_DEF = 18;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DONE
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned min_accw(input int unsigned n, input int unsigned dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate stage.
//   clk, rst   : clock, synchronous active-high reset (clears acc)
//   en         : perform one MAC this cycle
//   load_init  : start a new sum from acc_in instead of the current acc
//   signed_sel : 1 = operands are two's complement, product sign-extended
//   a, b       : DW-bit operands
//   acc_in     : initial value for a new sum
//   acc        : registered ACCW-bit accumulator
module mac_unit #(
  parameter int unsigned DW   = 8,
  parameter int unsigned ACCW = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load_init,
  input  logic            signed_sel,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [ACCW-1:0] acc_in,
  output logic [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod_s;
  logic        [2*DW-1:0] prod_u;
  logic        [ACCW-1:0] prod_ext;
  logic        [ACCW-1:0] base;

  always_comb begin
    prod_s   = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    prod_u   = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    prod_ext = signed_sel ? {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s}
                          : {{(ACCW-2*DW){1'b0}}, prod_u};
    base     = load_init ? acc_in : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= base + prod_ext;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// N x N matrix-multiply engine: C = A*B or C += A*B, one MAC per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   load_en, load_sel_ab, load_index, in_data : element write into A (0) or B (1)
//   signed_mode, acc_mode : arithmetic / accumulate select, latched on COMPUTE entry
//   clear               : abort, zero C, clear load masks (A and B retained)
//   output_en, output_sel : read request for C[output_sel]
//   out_data, out_valid : registered read data and its one-cycle strobe
//   busy, done          : high in COMPUTE / DONE
module matmul_engine
  import matmul_pkg::*;
#(
  parameter  int unsigned N    = N_DEF,
  parameter  int unsigned DW   = DW_DEF,
  parameter  int unsigned ACCW = ACCW_DEF,
  localparam int unsigned IW   = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic            load_sel_ab,
  input  logic [IW-1:0]   load_index,
  input  logic [DW-1:0]   in_data,
  input  logic            signed_mode,
  input  logic            acc_mode,
  input  logic            clear,
  input  logic            output_en,
  input  logic [IW-1:0]   output_sel,
  output logic [ACCW-1:0] out_data,
  output logic            out_valid,
  output logic            busy,
  output logic            done
);

  localparam int unsigned NE = N * N;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  state_t          state;
  logic [DW-1:0]   mat_a [NE];
  logic [DW-1:0]   mat_b [NE];
  logic [ACCW-1:0] mat_c [NE];
  logic [NE-1:0]   mask_a;
  logic [NE-1:0]   mask_b;
  logic [CW-1:0]   ci, cj, ck;
  logic            signed_q, acc_q;
  logic            issue_done;
  logic            wb_pending;
  logic [IW-1:0]   wb_idx;

  logic            full, start, issue, eff_signed, eff_acc, load_ok, read_ok;
  logic [IW-1:0]   a_idx, b_idx, c_idx;
  logic [ACCW-1:0] mac_init, mac_acc;

  // The MAC pipeline is primed in the LOAD cycle that sees both masks full,
  // so the registered accumulator can be written back one cycle after the
  // k = N-1 product while still finishing within the N^3 COMPUTE cycles.
  always_comb begin
    full       = (&mask_a) && (&mask_b);
    start      = (state == LOAD) && full;
    issue      = start || ((state == COMPUTE) && !issue_done);
    eff_signed = (state == COMPUTE) ? signed_q : signed_mode;
    eff_acc    = (state == COMPUTE) ? acc_q    : acc_mode;
    a_idx      = IW'(32'(ci) * N + 32'(ck));
    b_idx      = IW'(32'(ck) * N + 32'(cj));
    c_idx      = IW'(32'(ci) * N + 32'(cj));
    mac_init   = eff_acc ? mat_c[c_idx] : '0;
    load_ok    = load_en && (32'(load_index) < NE);
    read_ok    = 32'(output_sel) < NE;
  end

  mac_unit #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk        (clk),
    .rst        (rst || clear),
    .en         (issue),
    .load_init  (ck == '0),
    .signed_sel (eff_signed),
    .a          (mat_a[a_idx]),
    .b          (mat_b[b_idx]),
    .acc_in     (mac_init),
    .acc        (mac_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      for (int unsigned e = 0; e < NE; e++) begin
        mat_a[e] <= '0;
        mat_b[e] <= '0;
        mat_c[e] <= '0;
      end
      mask_a     <= '0;
      mask_b     <= '0;
      ci         <= '0;
      cj         <= '0;
      ck         <= '0;
      signed_q   <= 1'b0;
      acc_q      <= 1'b0;
      issue_done <= 1'b0;
      wb_pending <= 1'b0;
      wb_idx     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      state      <= LOAD;
      for (int unsigned e = 0; e < NE; e++) begin
        mat_c[e] <= '0;
      end
      mask_a     <= '0;
      mask_b     <= '0;
      ci         <= '0;
      cj         <= '0;
      ck         <= '0;
      issue_done <= 1'b0;
      wb_pending <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      if (wb_pending) begin
        mat_c[wb_idx] <= mac_acc;
      end
      wb_pending <= issue && (ck == C_LAST);
      wb_idx     <= c_idx;

      if (issue) begin
        if (ck == C_LAST) begin
          ck <= '0;
          if (cj == C_LAST) begin
            cj <= '0;
            if (ci == C_LAST) begin
              ci         <= '0;
              issue_done <= 1'b1;
            end else begin
              ci <= ci + CW'(1);
            end
          end else begin
            cj <= cj + CW'(1);
          end
        end else begin
          ck <= ck + CW'(1);
        end
      end

      case (state)
        LOAD: begin
          if (start) begin
            state    <= COMPUTE;
            busy     <= 1'b1;
            signed_q <= signed_mode;
            acc_q    <= acc_mode;
          end else if (load_ok) begin
            if (load_sel_ab) begin
              mat_b[load_index]  <= in_data;
              mask_b[load_index] <= 1'b1;
            end else begin
              mat_a[load_index]  <= in_data;
              mask_a[load_index] <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (issue_done) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            issue_done <= 1'b0;
          end
        end
        DONE: begin
          if (load_en) begin
            // Masks restart empty; only this write is recorded.
            mask_a <= '0;
            mask_b <= '0;
            if (load_ok) begin
              if (load_sel_ab) begin
                mat_b[load_index]  <= in_data;
                mask_b[load_index] <= 1'b1;
              end else begin
                mat_a[load_index]  <= in_data;
                mask_a[load_index] <= 1'b1;
              end
            end
            done  <= 1'b0;
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase

      if (output_en) begin
        out_valid <= 1'b1;
        out_data  <= read_ok ? mat_c[output_sel] : '0;
      end
    end
  end

endmodule
